// File: rtl/control_logic_unit_p.sv
// rtl/control_logic_unit_p.sv - edge-triggered command decoder with delayed one-hot strobes
// Sticky overrun/bad-address status; soft clear rides in the command word MSB.
module control_logic_unit_p #(
  parameter int DATA_W   = 16,
  parameter int ADDR_LSB = 8,
  parameter int ADDR_W   = 5,
  parameter int N_REG    = 16,
  parameter int N_DIR    = 4,
  parameter int DELAY    = 3,
  parameter int PULSE_W  = 1,
  parameter int GAP      = 1
) (
  input  logic              CLK,
  input  logic              CLR_n,
  input  logic [DATA_W-1:0] data_in,
  output logic [N_REG-1:0]  strob_out_to_reg,
  output logic [N_DIR-1:0]  strob_out_to_dir,
  output logic              busy,
  output logic              overrun,
  output logic              bad_addr
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_STROBE, S_GAP} state_t;

  localparam int MAXC = (DELAY > PULSE_W) ? ((DELAY > GAP) ? DELAY : GAP)
                                          : ((PULSE_W > GAP) ? PULSE_W : GAP);
  localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] DLY_LD = CW'(DELAY - 1);
  localparam logic [CW-1:0] PW_LD  = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(N_REG + N_DIR);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N_REG-1:0]  reg_q, reg_d, reg_sel;
  logic [N_DIR-1:0]  dir_q, dir_d, dir_sel;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic              bad_q, bad_d;

  logic              soft_clr, req, req_edge, cnt_zero, done, can_accept, addr_bad;
  logic [ADDR_W-1:0] addr_in;
  logic              unused_data;

  assign soft_clr    = data_in[DATA_W-1];
  assign req         = data_in[DATA_W-2];
  assign addr_in     = data_in[ADDR_LSB+ADDR_W-1:ADDR_LSB];
  assign unused_data = ^data_in;
  assign req_edge    = req & ~req_q;
  assign cnt_zero    = (cnt_q == '0);

  // The last holdoff cycle already accepts a new edge, so back-to-back commands
  // are spaced exactly DELAY+PULSE_W+GAP edges apart.
  assign done = ((state_q == S_STROBE) && cnt_zero && (GAP == 0)) ||
                ((state_q == S_GAP) && cnt_zero);
  assign can_accept = (state_q == S_IDLE) || done;

  always_comb begin
    reg_sel = '0;
    dir_sel = '0;
    for (int i = 0; i < N_REG; i++) reg_sel[i] = (addr_q == ADDR_W'(i));
    for (int i = 0; i < N_DIR; i++) dir_sel[i] = ({1'b0, addr_q} == (ADDR_W+1)'(N_REG + i));
    addr_bad = ({1'b0, addr_q} >= ADDR_LIM);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q;
    bad_d   = bad_q;
    req_d   = req;
    if (soft_clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      reg_d   = '0;
      dir_d   = '0;
      busy_d  = 1'b0;
      ovr_d   = 1'b0;
      bad_d   = 1'b0;
    end else begin
      case (state_q)
        S_DELAY: begin
          if (cnt_zero) begin
            state_d = S_STROBE;
            cnt_d   = PW_LD;
            reg_d   = reg_sel;
            dir_d   = dir_sel;
            if (addr_bad) bad_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_STROBE: begin
          if (cnt_zero) begin
            reg_d = '0;
            dir_d = '0;
            if (GAP == 0) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = S_GAP;
              cnt_d   = GAP_LD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_zero) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
      if (req_edge) begin
        if (can_accept) begin
          state_d = S_DELAY;
          cnt_d   = DLY_LD;
          addr_d  = addr_in;
          busy_d  = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      reg_q   <= '0;
      dir_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      bad_q   <= bad_d;
    end
  end

  assign strob_out_to_reg = reg_q;
  assign strob_out_to_dir = dir_q;
  assign busy             = busy_q;
  assign overrun          = ovr_q;
  assign bad_addr         = bad_q;

endmodule

// File: tb/tb_control_logic_unit_p.sv
// tb/tb_control_logic_unit_p.sv - scoreboard bench for control_logic_unit_p
// Instance A uses default timing, instance B uses DELAY=1, PULSE_W=3, GAP=2.
module tb_control_logic_unit_p;

  typedef struct {int cyc; logic busy; logic ov; logic bad;} st_t;
  typedef struct {int cyc; logic [15:0] r; logic [3:0] d;} sb_t;

  logic        CLK = 1'b0;
  logic        CLR_n = 1'b0;
  logic [15:0] da = '0, db = '0;
  logic [15:0] a_reg, b_reg;
  logic [3:0]  a_dir, b_dir;
  logic        a_busy, a_ov, a_bad, b_busy, b_ov, b_bad;
  int          edge_n = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  st_t st_a[$], st_b[$];
  sb_t sb_a[$], sb_b[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_n <= edge_n + 1;

  control_logic_unit_p u_a (
    .CLK(CLK), .CLR_n(CLR_n), .data_in(da),
    .strob_out_to_reg(a_reg), .strob_out_to_dir(a_dir),
    .busy(a_busy), .overrun(a_ov), .bad_addr(a_bad)
  );

  control_logic_unit_p #(.DELAY(1), .PULSE_W(3), .GAP(2)) u_b (
    .CLK(CLK), .CLR_n(CLR_n), .data_in(db),
    .strob_out_to_reg(b_reg), .strob_out_to_dir(b_dir),
    .busy(b_busy), .overrun(b_ov), .bad_addr(b_bad)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", nm, edge_n, act, exp);
    end
  endtask

  task automatic est_a(input int c, input logic b, input logic o, input logic bd);
    st_a.push_back('{c, b, o, bd});
  endtask
  task automatic est_b(input int c, input logic b, input logic o, input logic bd);
    st_b.push_back('{c, b, o, bd});
  endtask
  task automatic esb_a(input int c, input logic [15:0] r, input logic [3:0] d);
    sb_a.push_back('{c, r, d});
  endtask
  task automatic esb_b(input int c, input logic [15:0] r, input logic [3:0] d);
    sb_b.push_back('{c, r, d});
  endtask

  task automatic drv_a(input logic [15:0] v);
    @(negedge CLK);
    da = v;
  endtask
  task automatic drv_b(input logic [15:0] v);
    @(negedge CLK);
    db = v;
  endtask
  task automatic idle_a(input int n);
    repeat (n) drv_a(16'h0000);
  endtask
  task automatic idle_b(input int n);
    repeat (n) drv_b(16'h0000);
  endtask

  always @(negedge CLK) begin : mon_a
    st_t e;
    sb_t s;
    while (st_a.size() > 0 && st_a[0].cyc <= edge_n) begin
      e = st_a.pop_front();
      chk("A_status_cycle", edge_n, e.cyc);
      chk("A_busy", int'(a_busy), int'(e.busy));
      chk("A_overrun", int'(a_ov), int'(e.ov));
      chk("A_bad_addr", int'(a_bad), int'(e.bad));
    end
    if (a_reg != '0 || a_dir != '0) begin
      chk("A_onehot", $countones({a_reg, a_dir}), 1);
      if (sb_a.size() == 0) begin
        chk("A_unexpected_strobe", int'({a_reg, a_dir}), 0);
      end else begin
        s = sb_a.pop_front();
        chk("A_strobe_cycle", edge_n, s.cyc);
        chk("A_reg_strobe", int'(a_reg), int'(s.r));
        chk("A_dir_strobe", int'(a_dir), int'(s.d));
      end
    end
  end

  always @(negedge CLK) begin : mon_b
    st_t e;
    sb_t s;
    while (st_b.size() > 0 && st_b[0].cyc <= edge_n) begin
      e = st_b.pop_front();
      chk("B_status_cycle", edge_n, e.cyc);
      chk("B_busy", int'(b_busy), int'(e.busy));
      chk("B_overrun", int'(b_ov), int'(e.ov));
      chk("B_bad_addr", int'(b_bad), int'(e.bad));
    end
    if (b_reg != '0 || b_dir != '0) begin
      chk("B_onehot", $countones({b_reg, b_dir}), 1);
      if (sb_b.size() == 0) begin
        chk("B_unexpected_strobe", int'({b_reg, b_dir}), 0);
      end else begin
        s = sb_b.pop_front();
        chk("B_strobe_cycle", edge_n, s.cyc);
        chk("B_reg_strobe", int'(b_reg), int'(s.r));
        chk("B_dir_strobe", int'(b_dir), int'(s.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, j;
    est_a(1, 1'b0, 1'b0, 1'b0);
    est_b(1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    CLR_n = 1'b1;
    idle_a(2);

    // single command to reg 3
    drv_a(16'h4300); k = edge_n + 1;
    esb_a(k + 3, 16'h0008, 4'h0);
    est_a(k, 1, 0, 0); est_a(k + 4, 1, 0, 0); est_a(k + 5, 0, 0, 0);
    idle_a(7);

    // direction strobe, addr 17
    drv_a(16'h5100); k = edge_n + 1;
    esb_a(k + 3, 16'h0000, 4'b0010);
    est_a(k + 3, 1, 0, 0); est_a(k + 5, 0, 0, 0);
    idle_a(7);

    // out-of-range addr 25
    drv_a(16'h5900); k = edge_n + 1;
    est_a(k + 2, 1, 0, 0); est_a(k + 3, 1, 0, 1); est_a(k + 4, 1, 0, 1); est_a(k + 5, 0, 0, 1);
    idle_a(7);
    drv_a(16'h8000); k = edge_n + 1;
    est_a(k, 0, 0, 0);
    idle_a(2);

    // overrun, then soft clear while busy
    drv_a(16'h4300); k = edge_n + 1;
    esb_a(k + 3, 16'h0008, 4'h0);
    est_a(k + 2, 1, 1, 0); est_a(k + 3, 1, 1, 0); est_a(k + 4, 0, 0, 0);
    drv_a(16'h0000); drv_a(16'h4500); drv_a(16'h0000); drv_a(16'h8000);
    idle_a(4);

    // level-held request
    drv_a(16'h4200); k = edge_n + 1;
    esb_a(k + 3, 16'h0004, 4'h0);
    est_a(k + 5, 0, 0, 0); est_a(k + 10, 0, 0, 0); est_a(k + 19, 0, 0, 0);
    repeat (19) drv_a(16'h4200);
    idle_a(3);

    // soft clear and request edge together
    drv_a(16'hC300); k = edge_n + 1;
    est_a(k, 0, 0, 0); est_a(k + 1, 0, 0, 0); est_a(k + 4, 0, 0, 0);
    drv_a(16'h4300);
    idle_a(5);

    // async reset during DELAY
    drv_a(16'h4100); k = edge_n + 1;
    drv_a(16'h0000);
    @(posedge CLK);
    #2;
    CLR_n = 1'b0;
    est_a(k + 1, 0, 0, 0);
    @(negedge CLK);
    @(negedge CLK);
    CLR_n = 1'b1;
    est_a(k + 4, 0, 0, 0); est_a(k + 8, 0, 0, 0);
    idle_a(6);
    drv_a(16'h4100); k = edge_n + 1;
    esb_a(k + 3, 16'h0002, 4'h0);
    est_a(k + 1, 1, 0, 0); est_a(k + 5, 0, 0, 0);
    idle_a(7);

    // instance B: edge at k+5 is overrun
    drv_b(16'h4600); k = edge_n + 1;
    esb_b(k + 1, 16'h0040, 4'h0); esb_b(k + 2, 16'h0040, 4'h0); esb_b(k + 3, 16'h0040, 4'h0);
    est_b(k, 1, 0, 0); est_b(k + 5, 1, 1, 0); est_b(k + 6, 0, 1, 0);
    idle_b(4); drv_b(16'h4700); idle_b(4);
    drv_b(16'h8000); j = edge_n + 1;
    est_b(j, 0, 0, 0);
    idle_b(2);

    // instance B: edge at k+6 is accepted
    drv_b(16'h4600); k = edge_n + 1;
    esb_b(k + 1, 16'h0040, 4'h0); esb_b(k + 2, 16'h0040, 4'h0); esb_b(k + 3, 16'h0040, 4'h0);
    esb_b(k + 7, 16'h0002, 4'h0); esb_b(k + 8, 16'h0002, 4'h0); esb_b(k + 9, 16'h0002, 4'h0);
    est_b(k + 6, 1, 0, 0); est_b(k + 11, 1, 0, 0); est_b(k + 12, 0, 0, 0);
    idle_b(5); drv_b(16'h4100); idle_b(8);

    @(negedge CLK);
    chk("A_strobes_missing", sb_a.size(), 0);
    chk("B_strobes_missing", sb_b.size(), 0);
    chk("A_status_pending", st_a.size(), 0);
    chk("B_status_pending", st_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
